// File: rtl/argmax_scheduler.sv
// Sequential argmax over a frame of NUM_CLASS signed scores, one beat per cycle.
// A single signed comparator is time-shared across the beats; the result is handed off with valid/ready.
module argmax_scheduler #(
   parameter int DATA_WIDTH = 28,
   parameter int NUM_CLASS  = 10,
   parameter int IDX_WIDTH  = 8,
   parameter int FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_WIDTH-1:0]  predict,
   output logic [DATA_WIDTH-1:0] max_score,
   output logic                  busy,
   output logic [FCNT_WIDTH-1:0] frame_cnt
);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

   state_t                state_reg, state_next;
   logic [IDX_WIDTH-1:0]  cnt_reg, cnt_next;
   logic [IDX_WIDTH-1:0]  idx_reg, idx_next;
   logic [DATA_WIDTH-1:0] max_reg, max_next;
   logic [IDX_WIDTH-1:0]  predict_reg, predict_next;
   logic [DATA_WIDTH-1:0] score_reg, score_next;
   logic [FCNT_WIDTH-1:0] fcnt_reg, fcnt_next;
   logic                  beat;
   logic                  ge;

   // Differing signs: the non-negative operand wins; equal signs: low bits compare unsigned.
   always_comb begin
      if (in_data[DATA_WIDTH-1] != max_reg[DATA_WIDTH-1])
         ge = ~in_data[DATA_WIDTH-1];
      else
         ge = (in_data[DATA_WIDTH-2:0] >= max_reg[DATA_WIDTH-2:0]);
   end

   assign beat = in_valid && (state_reg == COLLECT);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      idx_next     = idx_reg;
      max_next     = max_reg;
      predict_next = predict_reg;
      score_next   = score_reg;
      fcnt_next    = fcnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = COLLECT;
               cnt_next   = '0;
            end
         end
         COLLECT: begin
            if (beat) begin
               if ((cnt_reg == '0) || ge) begin
                  max_next = in_data;
                  idx_next = cnt_reg;
               end
               cnt_next = cnt_reg + 1'b1;
               // The final beat's compare result is captured straight into the output registers.
               if (cnt_reg == LAST_IDX) begin
                  predict_next = idx_next;
                  score_next   = max_next;
                  state_next   = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               fcnt_next = fcnt_reg + 1'b1;
               cnt_next  = '0;
               state_next = start ? COLLECT : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         max_reg     <= '0;
         predict_reg <= '0;
         score_reg   <= '0;
         fcnt_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         max_reg     <= max_next;
         predict_reg <= predict_next;
         score_reg   <= score_next;
         fcnt_reg    <= fcnt_next;
      end
   end

   assign in_ready  = (state_reg == COLLECT);
   assign out_valid = (state_reg == HOLD);
   assign busy      = (state_reg != IDLE);
   assign predict   = predict_reg;
   assign max_score = score_reg;
   assign frame_cnt = fcnt_reg;

endmodule

// File: tb/tb_argmax_scheduler.sv
// Self-checking bench for argmax_scheduler: vector table plus hand-written corner sequences,
// results checked through a scoreboard queue. A second instance with a 2-bit frame counter checks wrap.
module tb_argmax_scheduler;

   localparam int DW = 28;
   localparam int NC = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, busy;
   logic [7:0]    predict;
   logic [DW-1:0] max_score;
   logic [15:0]   frame_cnt;
   logic          in_ready2, out_valid2, busy2;
   logic [7:0]    predict2;
   logic [DW-1:0] max_score2;
   logic [1:0]    frame_cnt2;

   argmax_scheduler #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .IDX_WIDTH(8), .FCNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .predict(predict),
      .max_score(max_score), .busy(busy), .frame_cnt(frame_cnt));

   argmax_scheduler #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .IDX_WIDTH(8), .FCNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready), .predict(predict2),
      .max_score(max_score2), .busy(busy2), .frame_cnt(frame_cnt2));

   always #5 clk = ~clk;

   typedef struct {
      int s [NC];
      int exp_idx;
      int exp_max;
   } vec_t;

   typedef struct {
      int idx;
      int mx;
   } res_t;

   vec_t tbl [4];
   res_t sb_q [$];
   int   tests = 0;
   int   fails = 0;
   int   exp_fcnt = 0;

   function automatic logic [DW-1:0] to_d(input int x);
      return x[DW-1:0];
   endfunction

   function automatic res_t model(input int s [NC]);
      res_t r;
      r.idx = 0;
      r.mx  = s[0];
      for (int i = 1; i < NC; i++) begin
         if (s[i] >= r.mx) begin
            r.mx  = s[i];
            r.idx = i;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start a frame from IDLE and stream its beats; stall_mask[i] inserts one idle cycle before beat i.
   task automatic send_frame(input int s [NC], input logic [NC-1:0] stall_mask);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("in_ready_after_start", 64'(in_ready), 64'd1);
      for (int i = 0; i < NC; i++) begin
         if (stall_mask[i]) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("in_ready_stall", 64'(in_ready), 64'd1);
         end
         check("no_early_out_valid", 64'(out_valid), 64'd0);
         in_valid = 1'b1;
         in_data  = to_d(s[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("out_valid_latency", 64'(out_valid), 64'd1);
   endtask

   // Hold the result under backpressure for 'hold' cycles (toggling start/in_valid), then hand it off.
   task automatic take_result(input int hold);
      res_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      for (int k = 0; k < hold; k++) begin
         out_ready = 1'b0;
         start     = k[0];
         in_valid  = ~k[0];
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_predict", 64'(predict), 64'(e.idx[7:0]));
         check("bp_max_score", 64'(max_score), 64'(to_d(e.mx)));
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_frame_cnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("predict", 64'(predict), 64'(e.idx[7:0]));
      check("max_score", 64'(max_score), 64'(to_d(e.mx)));
      check("predict_w2", 64'(predict2), 64'(e.idx[7:0]));
      check("max_score_w2", 64'(max_score2), 64'(to_d(e.mx)));
      @(negedge clk);
      out_ready = 1'b0;
      exp_fcnt++;
      check("out_valid_after_handoff", 64'(out_valid), 64'd0);
      check("busy_after_handoff", 64'(busy), 64'd0);
      check("frame_cnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
      check("frame_cnt_wrap", 64'(frame_cnt2), 64'(exp_fcnt[1:0]));
   endtask

   initial begin
      int            fr [3][NC];
      int            s [NC];
      logic [NC-1:0] mask;
      res_t          e;
      int            f, b, nres, cyc;

      tbl[0].s = '{-5, 3, -100, 7, 0, -1, 6, 2, -7, 1};
      tbl[0].exp_idx = 3;  tbl[0].exp_max = 7;
      tbl[1].s = '{-9, -4, -8, -4, -20, -30, -4, -50, -60, -70};
      tbl[1].exp_idx = 6;  tbl[1].exp_max = -4;
      for (int i = 0; i < NC; i++) tbl[2].s[i] = -(1 << 27);
      tbl[2].s[0] = (1 << 27) - 1;
      tbl[2].exp_idx = 0;  tbl[2].exp_max = (1 << 27) - 1;
      for (int i = 0; i < NC; i++) tbl[3].s[i] = i;
      tbl[3].exp_idx = 9;  tbl[3].exp_max = 9;

      // Power-on reset
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_predict", 64'(predict), 64'd0);
      check("rst_max_score", 64'(max_score), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      rst = 1'b1;

      for (int t = 0; t < 4; t++) begin
         e.idx = tbl[t].exp_idx;
         e.mx  = tbl[t].exp_max;
         sb_q.push_back(e);
         send_frame(tbl[t].s, '0);
         take_result(0);
      end

      // Reset in the middle of collecting: partial frame is discarded
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = to_d(100 + i);
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      exp_fcnt = 0;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_predict", 64'(predict), 64'd0);
      check("midrst_max_score", 64'(max_score), 64'd0);
      check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("midrst_frame_cnt_w2", 64'(frame_cnt2), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_stays_idle", 64'(busy), 64'd0);

      e.idx = 9;  e.mx = 9;
      sb_q.push_back(e);
      send_frame(tbl[3].s, '0);
      take_result(0);

      // Stalls between beats, maximum at the last class
      for (int i = 0; i < NC - 1; i++) s[i] = int'($urandom_range(0, 1000)) - 500;
      s[NC-1] = 2000;
      mask = '0;
      while ($countones(mask) < 3) mask[$urandom_range(1, NC - 1)] = 1'b1;
      e.idx = 9;  e.mx = 2000;
      sb_q.push_back(e);
      send_frame(s, mask);
      take_result(0);

      // Backpressure for 5 cycles in HOLD
      for (int i = 0; i < NC; i++) s[i] = int'($urandom_range(0, 2000)) - 1000;
      sb_q.push_back(model(s));
      send_frame(s, '0);
      take_result(5);

      // Back-to-back frames with start and out_ready held high
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NC; i++) fr[k][i] = int'($urandom_range(0, 1 << 20)) - (1 << 19);
         sb_q.push_back(model(fr[k]));
      end
      @(negedge clk);
      start = 1'b1;  out_ready = 1'b1;  in_valid = 1'b1;
      f = 0;  b = 0;  nres = 0;  cyc = 0;
      while (nres < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            e = sb_q.pop_front();
            check("b2b_predict", 64'(predict), 64'(e.idx[7:0]));
            check("b2b_max_score", 64'(max_score), 64'(to_d(e.mx)));
            check("b2b_frame_cnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
            nres++;
            exp_fcnt++;
            if (nres == 3) begin
               start    = 1'b0;
               in_valid = 1'b0;
            end
         end
         if (in_ready && f < 3) begin
            in_data = to_d(fr[f][b]);
            b++;
            if (b == NC) begin
               b = 0;
               f++;
            end
         end
      end
      check("b2b_results", 64'(nres), 64'd3);
      check("b2b_cycles", 64'(cyc), 64'd33);
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_final_frame_cnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
      check("b2b_final_frame_cnt_w2", 64'(frame_cnt2), 64'(exp_fcnt[1:0]));
      check("b2b_idle", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/argmax_scheduler.md
# argmax_scheduler

Sequential argmax controller for the classifier output stage. It accepts the NUM_CLASS signed class scores of one inference as a stream of single-beat transfers and time-shares one signed comparator across them. It tracks the running maximum and its index and presents the predicted class with a valid/ready handshake. It sits between the serialized final fully-connected layer and the result sink, replacing the flat ten-way comparator tree when scores arrive one per cycle.

## Interface
- DATA_WIDTH, 28, width of one signed two's-complement class score
- NUM_CLASS, 10, scores per inference (2..255)
- IDX_WIDTH, 8, width of predict; must hold NUM_CLASS-1
- FCNT_WIDTH, 16, width of frame counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request to begin a new inference frame
- in_valid  in  1  score beat valid
- in_data  in  DATA_WIDTH  signed score, class index = beat order within frame
- in_ready  out  1  scheduler accepts a beat this cycle
- out_valid  out  1  predict/max_score valid
- out_ready  in  1  sink accepts result
- predict  out  IDX_WIDTH  winning class index, zero-extended
- max_score  out  DATA_WIDTH  winning score
- busy  out  1  high in COLLECT or HOLD
- frame_cnt  out  FCNT_WIDTH  completed (handed-off) frames, wraps modulo 2^FCNT_WIDTH

## Operation
- FSM states: IDLE, COLLECT, HOLD. Beat counter cnt (IDX_WIDTH bits), running max_r, running idx_r.
- IDLE: in_ready=0, out_valid=0. start=1 -> COLLECT, cnt<=0.
- COLLECT: in_ready=1. Beat accepted when in_valid&in_ready.
  - cnt==0: max_r<=in_data, idx_r<=0 unconditionally.
  - cnt>0: if signed(in_data) >= signed(max_r) then max_r<=in_data, idx_r<=cnt. Ties resolve to the higher index, matching the existing comparator tree.
  - cnt increments per accepted beat. The beat with cnt==NUM_CLASS-1 moves the FSM to HOLD; the compare for that beat still applies.
  - in_valid=0 cycles stall without effect. start is ignored.
- HOLD: in_ready=0, out_valid=1, predict=idx_r, max_score=max_r. These are stable until handshake.
  - out_valid&out_ready: frame_cnt++. If start=1 in the same cycle, go to COLLECT with cnt<=0. Otherwise go to IDLE.
  - start without handshake is ignored.
- predict/max_score keep their last value after leaving HOLD. They are only meaningful while out_valid=1.
- Signed compare: sign bit differing selects the non-negative operand. Otherwise compare magnitudes unsigned. The result equals a signed DATA_WIDTH compare. No widening or saturation.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE, in_ready=0, out_valid=0, busy=0, predict=0, max_score=0, frame_cnt=0, cnt=0.
  - Reset mid-COLLECT or mid-HOLD discards the partial or unconsumed frame with no output.
- All outputs are registered. in_ready and busy are decoded from the state register.
- start sampled in IDLE at edge N: in_ready=1 from cycle N+1.
- Final beat accepted at edge M: out_valid=1 from cycle M+1. Latency is 1 cycle from last beat to result. With in_valid held high, frame-to-result takes NUM_CLASS+1 cycles after start is accepted.
- Back-to-back throughput: with start held high and out_ready=1, a new frame's first beat is accepted in the cycle after the handshake. One bubble cycle per frame.
- frame_cnt updates on the handshake edge. 2^FCNT_WIDTH-1 wraps to 0.

## Test plan
- Reset: drive rst=0 for 2 cycles mid-COLLECT after 4 beats -> all outputs 0, IDLE; a subsequent full frame of scores 0..9 gives predict=9, max_score=9.
- Mixed signs: scores {-5, 3, -100, 7, 0, -1, 6, 2, -7, 1} (28-bit) -> predict=3, max_score=7, out_valid 1 cycle after 10th beat.
- All negative with tie: {-9,-4,-8,-4,-20,-30,-4,-50,-60,-70} -> predict=6, max_score=-4 (highest tied index). Extremes: 0x8000000 everywhere except class 0 = 0x7FFFFFF -> predict=0.
- Input stalls: deassert in_valid for 3 random cycles between beats, score max at class 9 -> predict=9; in_ready stays 1 throughout COLLECT; no extra beats counted.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while toggling in_valid and start -> out_valid, predict, max_score stable; in_ready=0; frame_cnt unchanged until handshake, then +1.
- Back-to-back: 3 frames with start and out_ready tied high -> three results, frame_cnt=3, exactly one idle cycle between frames. Force frame_cnt wrap with FCNT_WIDTH=2 over 5 frames -> frame_cnt=1.
